// File: rtl/config_readback.sv
// rtl/config_readback.sv - serial configuration chain readback into valid/ready words
//
// Optional feature macro: READBACK_LOOPBACK_EN (recirculate sampled bits for non-destructive readback)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, target              1-cycle readback request, chain select (0=CLB 1=SB 2=CB 3=reserved)
//   bit_out_clb/sb/cb          serial outputs of the three chains
//   shift_en_clb/sb/cb         advance the selected chain on this edge
//   bit_in_clb/sb/cb           bit shifted into the chain tail
//   word_data/valid/ready/last packed LSB-first readback words, last qualifies final word
//   busy, done, err            activity flag, completion pulse, reserved-target pulse
module config_readback #(
    parameter int WORD_W   = 8,
    parameter int CLB_BITS = 296,
    parameter int SB_BITS  = 384,
    parameter int CB_BITS  = 104
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        target,
    input  logic              bit_out_clb,
    input  logic              bit_out_sb,
    input  logic              bit_out_cb,
    output logic              shift_en_clb,
    output logic              shift_en_sb,
    output logic              shift_en_cb,
    output logic              bit_in_clb,
    output logic              bit_in_sb,
    output logic              bit_in_cb,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

    state_t            state, state_nx;
    logic [1:0]        sel;
    logic [15:0]       len, cnt, len_sel;
    logic [IW-1:0]     widx;
    logic [WORD_W-1:0] asm_q, out_q, next_word;
    logic              out_v, out_l, err_q;
    logic              sample_bit, last_bit, word_end, accept, stall, shift, req_ok;

    always_comb begin
        sample_bit = 1'b0;
        case (sel)
            2'd0:    sample_bit = bit_out_clb;
            2'd1:    sample_bit = bit_out_sb;
            default: sample_bit = bit_out_cb;
        endcase

        len_sel = 16'(CB_BITS);
        if (target == 2'd0)      len_sel = 16'(CLB_BITS);
        else if (target == 2'd1) len_sel = 16'(SB_BITS);

        req_ok    = (state == S_IDLE) && start && (target != 2'd3);
        last_bit  = (cnt + 16'd1 == len);
        word_end  = (widx == IW'(WORD_W - 1)) || last_bit;
        accept    = out_v && word_ready;
        // Hold the chain rather than overwrite a word the consumer has not taken yet.
        stall     = word_end && out_v && !word_ready;
        shift     = (state == S_SHIFT) && !stall && !reset;

        next_word       = asm_q;
        next_word[widx] = sample_bit;

        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE:  if (req_ok) state_nx = S_SHIFT;
            S_SHIFT: begin
                busy = 1'b1;
                if (shift && last_bit) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (accept && out_l) state_nx = S_DONE;
            end
            S_DONE:  begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            sel   <= 2'd0;
            len   <= 16'd0;
            cnt   <= 16'd0;
            widx  <= '0;
            asm_q <= '0;
            out_q <= '0;
            out_v <= 1'b0;
            out_l <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == S_IDLE) && start && (target == 2'd3);
            if (req_ok) begin
                sel   <= target;
                len   <= len_sel;
                cnt   <= 16'd0;
                widx  <= '0;
                asm_q <= '0;
            end
            if (shift) begin
                cnt <= cnt + 16'd1;
                if (word_end) begin
                    // Clearing the assembly register zero-pads a short final word.
                    out_q <= next_word;
                    out_l <= last_bit;
                    asm_q <= '0;
                    widx  <= '0;
                end else begin
                    asm_q <= next_word;
                    widx  <= widx + IW'(1);
                end
            end
            if (shift && word_end) begin
                out_v <= 1'b1;
            end else if (accept) begin
                out_v <= 1'b0;
                out_l <= 1'b0;
            end
        end
    end

    assign shift_en_clb = shift && (sel == 2'd0);
    assign shift_en_sb  = shift && (sel == 2'd1);
    assign shift_en_cb  = shift && (sel == 2'd2);
    assign word_data    = out_q;
    assign word_valid   = out_v;
    assign word_last    = out_l;
    assign err          = err_q;

`ifdef READBACK_LOOPBACK_EN
    // Feeding each sampled bit back into the tail restores the chain after LEN shifts.
    assign bit_in_clb = shift_en_clb && bit_out_clb;
    assign bit_in_sb  = shift_en_sb  && bit_out_sb;
    assign bit_in_cb  = shift_en_cb  && bit_out_cb;
`else
    assign bit_in_clb = 1'b0;
    assign bit_in_sb  = 1'b0;
    assign bit_in_cb  = 1'b0;
`endif
endmodule

// File: tb/tb_config_readback.sv
// tb/tb_config_readback.sv - self-checking bench for config_readback
module tb_config_readback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, start1 = 1'b0, start2 = 1'b0, word_ready = 1'b1;
    logic [1:0]  target = 2'd0;
    logic        bo_clb, bo_sb, bo_cb, se_clb, se_sb, se_cb, bi_clb, bi_sb, bi_cb;
    logic [7:0]  wd1;
    logic        wv1, wl1, busy1, done1, err1;
    logic        bo2_clb, se2_clb, se2_sb, se2_cb, bi2_clb, bi2_sb, bi2_cb;
    logic [15:0] wd2;
    logic        wv2, wl2, busy2, done2, err2;

    logic [295:0] clb_ch, clb2_ch;
    logic [383:0] sb_ch;
    logic [103:0] cb_ch;
    logic         ld_en = 1'b0;
    logic [1:0]   ld_sel = 2'd0;
    logic [383:0] ld_val = '0;

    config_readback dut1 (
        .clk(clk), .reset(reset), .start(start1), .target(target),
        .bit_out_clb(bo_clb), .bit_out_sb(bo_sb), .bit_out_cb(bo_cb),
        .shift_en_clb(se_clb), .shift_en_sb(se_sb), .shift_en_cb(se_cb),
        .bit_in_clb(bi_clb), .bit_in_sb(bi_sb), .bit_in_cb(bi_cb),
        .word_data(wd1), .word_valid(wv1), .word_ready(word_ready), .word_last(wl1),
        .busy(busy1), .done(done1), .err(err1));

    config_readback #(.WORD_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .target(target),
        .bit_out_clb(bo2_clb), .bit_out_sb(1'b0), .bit_out_cb(1'b0),
        .shift_en_clb(se2_clb), .shift_en_sb(se2_sb), .shift_en_cb(se2_cb),
        .bit_in_clb(bi2_clb), .bit_in_sb(bi2_sb), .bit_in_cb(bi2_cb),
        .word_data(wd2), .word_valid(wv2), .word_ready(word_ready), .word_last(wl2),
        .busy(busy2), .done(done2), .err(err2));

    // Chain models: bit 0 is the head presented on bit_out; bit_in enters at the tail.
    always @(posedge clk) begin
        if (ld_en) begin
            case (ld_sel)
                2'd0:    clb_ch  <= ld_val[295:0];
                2'd1:    sb_ch   <= ld_val;
                2'd2:    cb_ch   <= ld_val[103:0];
                default: clb2_ch <= ld_val[295:0];
            endcase
        end else begin
            if (se_clb)  clb_ch  <= {bi_clb, clb_ch[295:1]};
            if (se_sb)   sb_ch   <= {bi_sb, sb_ch[383:1]};
            if (se_cb)   cb_ch   <= {bi_cb, cb_ch[103:1]};
            if (se2_clb) clb2_ch <= {bi2_clb, clb2_ch[295:1]};
        end
    end
    assign bo_clb  = clb_ch[0];
    assign bo_sb   = sb_ch[0];
    assign bo_cb   = cb_ch[0];
    assign bo2_clb = clb2_ch[0];

    int errors = 0, checks = 0;
    logic [15:0] got [0:63];
    logic [15:0] pass1 [0:63];
    int nwords, nshift, last_cnt, last_pos, done_gap, hold_viol, other_se;
    bit tmo, first_busy;

    localparam logic [103:0] CB_PAT = 104'h0123456789ABCDEF0011223344;
    logic [7:0] cb_exp [0:12] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h00, 8'hEF, 8'hCD,
                                  8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};

    function automatic logic [383:0] sb_pattern();
        logic [383:0] p;
        for (int i = 0; i < 48; i++) p[i*8 +: 8] = 8'(i * 37 + 5);
        return p;
    endfunction

    task automatic load_chain(input logic [1:0] s, input logic [383:0] v);
        @(negedge clk);
        ld_en = 1'b1; ld_sel = s; ld_val = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Runs one readback and records what the consumer saw; the test tasks judge the results.
    task automatic readback(input bit which, input logic [1:0] tgt, input int stall_cycles);
        int stall_left, last_acc;
        logic pv, pr, pl, v, l, se, oth, dn;
        logic [15:0] pd, d;
        stall_left = 0; last_acc = 0; pv = 0; pr = 0; pl = 0; pd = '0;
        nwords = 0; nshift = 0; last_cnt = 0; last_pos = -1; done_gap = -1;
        hold_viol = 0; other_se = 0; tmo = 1;
        @(negedge clk);
        target = tgt; word_ready = 1'b1;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0; start2 = 1'b0;
        first_busy = which ? busy2 : busy1;
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) @(negedge clk);
            dn = which ? done2 : done1;
            if (dn) begin
                done_gap = c - last_acc;
                tmo = 0;
                break;
            end
            word_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            v = which ? wv2 : wv1;
            l = which ? wl2 : wl1;
            d = which ? wd2 : {8'h00, wd1};
            if (which) begin
                se  = (tgt == 2'd0) ? se2_clb : (tgt == 2'd1) ? se2_sb : se2_cb;
                oth = (se2_clb | se2_sb | se2_cb) & !se;
            end else begin
                se  = (tgt == 2'd0) ? se_clb : (tgt == 2'd1) ? se_sb : se_cb;
                oth = (se_clb | se_sb | se_cb) & !se;
            end
            if (oth) other_se++;
            if (pv && !pr && (!v || d !== pd || l !== pl)) hold_viol++;
            if (se) nshift++;
            if (v && word_ready) begin
                if (nwords < 64) got[nwords] = d;
                if (l) begin last_cnt++; last_pos = nwords; end
                nwords++;
                last_acc = c;
                if (nwords == 1) stall_left = stall_cycles;
            end
            pv = v; pr = word_ready; pd = d; pl = l;
        end
        word_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({busy1, done1, err1, wv1, wl1, se_clb, se_sb, se_cb, bi_clb, bi_sb, bi_cb} !== 11'b0 || wd1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b data=%h se=%b%b%b, want all 0", busy1, wv1, wd1, se_clb, se_sb, se_cb);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cb_readback(input int stall, input string name);
        load_chain(2'd2, {280'b0, CB_PAT});
        readback(0, 2'd2, stall);
        checks++;
        if (tmo !== 1'b0) begin errors++; $display("FAIL %s_timeout: no done seen", name); end
        checks++;
        if (first_busy !== 1'b1) begin errors++; $display("FAIL %s_busy: got %b want 1", name, first_busy); end
        checks++;
        if (nwords !== 13) begin errors++; $display("FAIL %s_words: got %0d want 13", name, nwords); end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (got[i] !== {8'h00, cb_exp[i]}) begin
                errors++;
                $display("FAIL %s_word%0d: got %h want %h", name, i, got[i], cb_exp[i]);
            end
        end
        checks++;
        if (last_pos !== 12 || last_cnt !== 1) begin
            errors++; $display("FAIL %s_last: got pos %0d count %0d want pos 12 count 1", name, last_pos, last_cnt);
        end
        checks++;
        if (nshift !== 104) begin errors++; $display("FAIL %s_shifts: got %0d want 104", name, nshift); end
        checks++;
        if (other_se !== 0) begin errors++; $display("FAIL %s_other_se: got %0d want 0", name, other_se); end
        checks++;
        if (hold_viol !== 0) begin errors++; $display("FAIL %s_hold: got %0d want 0", name, hold_viol); end
        checks++;
        if (done_gap !== 1) begin errors++; $display("FAIL %s_done_gap: got %0d want 1", name, done_gap); end
        @(negedge clk); #1;
        checks++;
        if (done1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL %s_done_pulse: got done=%b busy=%b want 0 0", name, done1, busy1);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        target = 2'd3; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        #1;
        checks++;
        if (err1 !== 1'b1 || busy1 !== 1'b0 || wv1 !== 1'b0 || {se_clb, se_sb, se_cb} !== 3'b000) begin
            errors++; $display("FAIL err_pulse: got err=%b busy=%b valid=%b want 1 0 0", err1, busy1, wv1);
        end
        @(negedge clk); #1;
        checks++;
        if (err1 !== 1'b0 || busy1 !== 1'b0) begin
            errors++; $display("FAIL err_one_cycle: got err=%b busy=%b want 0 0", err1, busy1);
        end
    endtask

    task automatic test_word16();
        load_chain(2'd3, {384{1'b1}});
        readback(1, 2'd0, 0);
        checks++;
        if (tmo !== 1'b0 || nwords !== 19) begin
            errors++; $display("FAIL w16_words: got %0d (timeout %b) want 19", nwords, tmo);
        end
        for (int i = 0; i < 19; i++) begin
            checks++;
            if (got[i] !== ((i == 18) ? 16'h00FF : 16'hFFFF)) begin
                errors++; $display("FAIL w16_word%0d: got %h want %h", i, got[i], (i == 18) ? 16'h00FF : 16'hFFFF);
            end
        end
        checks++;
        if (last_pos !== 18 || last_cnt !== 1) begin
            errors++; $display("FAIL w16_last: got pos %0d count %0d want 18 1", last_pos, last_cnt);
        end
        checks++;
        if (nshift !== 296) begin errors++; $display("FAIL w16_shifts: got %0d want 296", nshift); end
    endtask

    task automatic test_mid_reset();
        int n;
        bit hit;
        n = 0; hit = 0;
        load_chain(2'd1, sb_pattern());
        @(negedge clk);
        target = 2'd1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (se_sb) n++;
            if (n == 50) begin hit = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midrst_reach50: got %0d shifts want 50", n); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b0 || wv1 !== 1'b0 || {se_clb, se_sb, se_cb} !== 3'b000) begin
            errors++; $display("FAIL midrst_state: got busy=%b valid=%b se=%b%b%b want 0", busy1, wv1, se_clb, se_sb, se_cb);
        end
        readback(0, 2'd1, 0);
        checks++;
        if (tmo !== 1'b0 || nwords !== 48 || nshift !== 384) begin
            errors++; $display("FAIL midrst_rerun: got %0d words %0d shifts want 48 384", nwords, nshift);
        end
    endtask

    task automatic test_sb_twice();
        logic [383:0] p;
        p = sb_pattern();
        load_chain(2'd1, p);
        readback(0, 2'd1, 0);
        checks++;
        if (tmo !== 1'b0 || nwords !== 48) begin errors++; $display("FAIL sb1_words: got %0d want 48", nwords); end
        for (int i = 0; i < 48; i++) begin
            pass1[i] = got[i];
            checks++;
            if (got[i] !== {8'h00, p[i*8 +: 8]}) begin
                errors++; $display("FAIL sb1_word%0d: got %h want %h", i, got[i], p[i*8 +: 8]);
            end
        end
        readback(0, 2'd1, 0);
        checks++;
        if (tmo !== 1'b0 || nwords !== 48) begin errors++; $display("FAIL sb2_words: got %0d want 48", nwords); end
        for (int i = 0; i < 48; i++) begin
            checks++;
`ifdef READBACK_LOOPBACK_EN
            if (got[i] !== pass1[i]) begin
                errors++; $display("FAIL sb2_word%0d: got %h want %h", i, got[i], pass1[i]);
            end
`else
            if (got[i] !== 16'h0000) begin
                errors++; $display("FAIL sb2_word%0d: got %h want 0000", i, got[i]);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_cb_readback(0, "cb");
        test_cb_readback(10, "cb_stall");
        test_err();
        test_word16();
        test_mid_reset();
        test_sb_twice();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
